// File: rtl/id_stage_pipe.sv
// id_stage_pipe -- registered RISC-V instruction-decode stage.
//
// Sits between fetch and execute. Each accepted {pc, inst} is decoded
// combinationally on the input side and captured already decoded, so the
// execute side sees register indices, immediate, ALU opcode, one-hot class
// and an illegal flag straight from flops.
//
// Storage is a main register (drives out_*) plus one skid register. in_ready
// is the inverse of the skid-valid flop, so fetch never sees a combinational
// path from out_ready.
//
// Ports:
//   clk, rst            rising-edge clock, synchronous active-high reset
//   flush               drop every buffered entry (and any input beat) this cycle
//   in_valid/in_ready   fetch handshake, in_pc / in_inst payload
//   out_valid/out_ready execute handshake
//   out_pc, out_rs1, out_rs2, out_rd, out_imm, out_alu_op, out_cls, out_illegal
//                       decoded entry fields
//   dec_count           entries accepted by execute since reset (wraps)
module id_stage_pipe #(
    parameter int XLEN  = 32,
    parameter bit HAS_M = 1'b1,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [XLEN-1:0]  in_pc,
    input  logic [31:0]      in_inst,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_pc,
    output logic [4:0]       out_rs1,
    output logic [4:0]       out_rs2,
    output logic [4:0]       out_rd,
    output logic [XLEN-1:0]  out_imm,
    output logic [4:0]       out_alu_op,
    output logic [9:0]       out_cls,
    output logic             out_illegal,
    output logic [CNT_W-1:0] dec_count
);

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_IMM   = 7'b0010011;
    localparam logic [6:0] OP_L     = 7'b0000011;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_S     = 7'b0100011;
    localparam logic [6:0] OP_B     = 7'b1100011;
    localparam logic [6:0] OP_J     = 7'b1101111;
    localparam logic [6:0] OP_CSR   = 7'b1110011;

    // one-hot class bit positions
    localparam int C_R = 0, C_IMM = 1, C_LUI = 2, C_S = 3, C_B = 4;
    localparam int C_J = 5, C_CSR = 6, C_L = 7, C_AUIPC = 8, C_JALR = 9;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      rd;
        logic [XLEN-1:0] imm;
        logic [4:0]      alu_op;
        logic [9:0]      cls;
        logic            illegal;
    } entry_t;

    entry_t            dec_entry;
    entry_t            main_q, main_d, skid_q, skid_d;
    logic              main_vld_q, main_vld_d, skid_vld_q, skid_vld_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              acc, drain;

    // ------------------------------------------------------------------
    // Decode
    // ------------------------------------------------------------------
    logic [6:0]      opc;
    logic [2:0]      f3;
    logic [6:0]      f7;
    logic [XLEN-1:0] imm;
    logic [4:0]      alu;
    logic [9:0]      cls;
    logic            ill;
    logic            is_shift;

    assign opc      = in_inst[6:0];
    assign f3       = in_inst[14:12];
    assign f7       = in_inst[31:25];
    assign is_shift = (f3 == 3'b001) || (f3 == 3'b101);

    always_comb begin
        imm = '0;
        alu = '0;
        cls = '0;
        ill = 1'b0;
        case (opc)
            OP_R: begin
                cls[C_R] = 1'b1;
                alu      = {f7 == 7'b0000001, in_inst[30], f3};
                if (f7 == 7'b0100000)
                    ill = !((f3 == 3'b000) || (f3 == 3'b101));
                else if (f7 == 7'b0000001)
                    ill = !HAS_M;
                else if (f7 != 7'b0000000)
                    ill = 1'b1;
            end
            OP_IMM: begin
                cls[C_IMM] = 1'b1;
                alu        = {1'b0, (f3 == 3'b101) ? in_inst[30] : 1'b0, f3};
                if (is_shift) begin
                    // shamt is 5 bits on RV32, 6 on RV64; bit 25 set on RV32 is reserved
                    imm = (XLEN == 64) ? XLEN'(in_inst[25:20]) : XLEN'(in_inst[24:20]);
                    ill = (XLEN == 32) && in_inst[25];
                end else begin
                    imm = XLEN'($signed(in_inst[31:20]));
                end
            end
            OP_L: begin
                cls[C_L] = 1'b1;
                imm      = XLEN'($signed(in_inst[31:20]));
            end
            OP_JALR: begin
                cls[C_JALR] = 1'b1;
                imm         = XLEN'($signed(in_inst[31:20]));
            end
            OP_LUI: begin
                cls[C_LUI] = 1'b1;
                imm        = XLEN'($signed({in_inst[31:12], 12'b0}));
            end
            OP_AUIPC: begin
                cls[C_AUIPC] = 1'b1;
                imm          = XLEN'($signed({in_inst[31:12], 12'b0}));
            end
            OP_S: begin
                cls[C_S] = 1'b1;
                imm      = XLEN'($signed({in_inst[31:25], in_inst[11:7]}));
            end
            OP_B: begin
                cls[C_B] = 1'b1;
                imm      = XLEN'($signed({in_inst[31], in_inst[7], in_inst[30:25],
                                          in_inst[11:8], 1'b0}));
            end
            OP_J: begin
                cls[C_J] = 1'b1;
                imm      = XLEN'($signed({in_inst[31], in_inst[19:12], in_inst[20],
                                          in_inst[30:21], 1'b0}));
            end
            OP_CSR: begin
                cls[C_CSR] = 1'b1;
                imm        = XLEN'(in_inst[19:15]);
            end
            default: ill = 1'b1;
        endcase
        // compressed / reserved low bits never decode here
        if (in_inst[1:0] != 2'b11)
            ill = 1'b1;
        // illegal entries carry no decode payload downstream
        if (ill) begin
            imm = '0;
            alu = '0;
            cls = '0;
        end
    end

    always_comb begin
        dec_entry         = '0;
        dec_entry.pc      = in_pc;
        dec_entry.rs1     = in_inst[19:15];
        dec_entry.rs2     = in_inst[24:20];
        dec_entry.rd      = in_inst[11:7];
        dec_entry.imm     = imm;
        dec_entry.alu_op  = alu;
        dec_entry.cls     = cls;
        dec_entry.illegal = ill;
    end

    // ------------------------------------------------------------------
    // Main + skid storage
    // ------------------------------------------------------------------
    assign in_ready  = !skid_vld_q;
    assign out_valid = main_vld_q;
    assign acc       = in_valid && in_ready;
    assign drain     = main_vld_q && out_ready;

    always_comb begin
        main_d     = main_q;
        skid_d     = skid_q;
        main_vld_d = main_vld_q;
        skid_vld_d = skid_vld_q;
        // an out handshake in a flush cycle still counts
        cnt_d      = cnt_q + CNT_W'(drain);
        if (flush) begin
            main_vld_d = 1'b0;
            skid_vld_d = 1'b0;
        end else if (!main_vld_q || drain) begin
            // main is free after this edge: refill from skid first to keep order.
            // skid full implies in_ready=0, so acc cannot coincide with it.
            if (skid_vld_q) begin
                main_d     = skid_q;
                main_vld_d = 1'b1;
                skid_vld_d = 1'b0;
            end else if (acc) begin
                main_d     = dec_entry;
                main_vld_d = 1'b1;
            end else begin
                main_vld_d = 1'b0;
            end
        end else if (acc) begin
            skid_d     = dec_entry;
            skid_vld_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            main_q     <= '0;
            skid_q     <= '0;
            main_vld_q <= 1'b0;
            skid_vld_q <= 1'b0;
            cnt_q      <= '0;
        end else begin
            main_q     <= main_d;
            skid_q     <= skid_d;
            main_vld_q <= main_vld_d;
            skid_vld_q <= skid_vld_d;
            cnt_q      <= cnt_d;
        end
    end

    assign out_pc      = main_q.pc;
    assign out_rs1     = main_q.rs1;
    assign out_rs2     = main_q.rs2;
    assign out_rd      = main_q.rd;
    assign out_imm     = main_q.imm;
    assign out_alu_op  = main_q.alu_op;
    assign out_cls     = main_q.cls;
    assign out_illegal = main_q.illegal;
    assign dec_count   = cnt_q;

endmodule

// File: doc/id_stage_pipe.md
Name: id_stage_pipe

Overview:
Registered, parametrised RISC-V instruction-decode pipeline stage that sits between the fetch stage and the execute stage.
- Accepts {pc, inst} over a valid/ready handshake and splits out the register fields.
- Builds the XLEN-wide immediate, the ALU opcode and one-hot class flags, and flags illegal encodings.
- A 2-entry skid buffer breaks the ready path combinationally; supports RV32/RV64 and optional M-extension decode, flush, and a retired-decode counter.

Parameters:
XLEN, 32, datapath width; legal values 32 or 64; sets imm/pc width and shamt width (5 or 6).
HAS_M, 1, 1 = decode funct7=0000001 R-type as M-extension; 0 = those encodings are illegal.
CNT_W, 32, width of the decoded-instruction counter.

Ports:
clk in 1 rising-edge clock
rst in 1 synchronous active-high reset
flush in 1 discard all buffered entries this cycle
in_valid in 1 fetch presents an instruction
in_ready out 1 stage can accept (registered)
in_pc in XLEN instruction address
in_inst in 32 instruction word
out_valid out 1 decoded entry available
out_ready in 1 execute accepts the entry
out_pc out XLEN pc of the entry
out_rs1, out_rs2, out_rd out 5 each register indices (inst[19:15], [24:20], [11:7])
out_imm out XLEN decoded immediate
out_alu_op out 5 {m, f7b5, funct3}
out_cls out 10 one-hot {JALR, AUIPC, L, CSR, J, B, S, LUI, IMM, R} (bit 0 = R)
out_illegal out 1 entry is an illegal encoding
dec_count out CNT_W number of entries accepted by execute since reset

Behaviour:
Reset (rst=1 at clk edge):
- out_valid=0, in_ready=1, both buffer entries empty, dec_count=0.
- All out_* data fields are 0.

Handshake:
- Transfer in when in_valid && in_ready; transfer out when out_valid && out_ready.
- in_valid must stay high and in_pc/in_inst must stay stable until accepted.

Storage: main register (drives out_*) plus one skid register.
- Input with main empty, or with main draining this cycle and skid empty: written to main.
- Input while main is held: written to skid.
- Main drains with skid full: skid moves to main.
- in_ready next = skid empty after the update.
- Latency: accept at edge N, out_valid=1 after edge N; full throughput (1 per cycle) when out_ready is held high.

Ordering: strict FIFO order; no entry dropped or duplicated.

Flush (registered, highest priority after rst):
- Empties both entries and sets out_valid=0, in_ready=1.
- An in_valid beat presented in the flush cycle is discarded.
- dec_count is not affected, except that an out handshake in the same cycle still counts.

Decode (combinational on in_inst, captured at accept):
- Opcodes: R 0110011, IMM 0010011, L 0000011, JALR 1100111, LUI 0110111, AUIPC 0010111, S 0100011, B 1100011, J 1101111, CSR 1110011.
- Immediates are sign-extended from inst[31] to XLEN:
  - I-type: inst[31:20].
  - Shift-imm (IMM with funct3 001/101): zero-extended shamt, inst[24:20] (XLEN=32) or inst[25:20] (XLEN=64).
  - S: {inst[31:25], inst[11:7]}.
  - B: {inst[31], inst[7], inst[30:25], inst[11:8], 0}.
  - U: {inst[31:12], 12'b0}, sign-extended to XLEN.
  - J: {inst[31], inst[19:12], inst[20], inst[30:21], 0}.
  - CSR: zero-extended inst[19:15].
  - R: 0.
- alu_op:
  - R: {funct7==0000001, inst[30], funct3}.
  - IMM: {0, funct3==101 ? inst[30] : 0, funct3}.
  - All other classes: 0.

Illegal:
- Opcode not in the list.
- inst[1:0] != 11.
- R with funct7 not in {0000000, 0100000, 0000001 if HAS_M}.
- R with funct7=0100000 and funct3 not in {000, 101}.
- RV32 shift-imm with inst[25]=1.

An illegal entry sets out_cls=0, out_imm=0 and out_alu_op=0. It still flows through the stage in order with out_illegal=1.

dec_count: increments by 1 per out handshake and wraps modulo 2^CNT_W.

Test Plan:
- Reset, then XLEN=32; addi x1,x2,-1 (0xFFF10093) at pc 0x100 with out_ready=1 -> next cycle out_valid=1, rs1=2, rd=1, imm=0xFFFFFFFF, cls=IMM (bit1), alu_op=0, dec_count 1 after handshake.
- srai x3,x4,5 (0x40525193) -> imm=5, alu_op=0b01101. Then sub (0x40208033) -> alu_op=0b01000, cls=R.
- Back-pressure: stream 4 instructions with out_ready=0 -> in_ready drops after 2 accepts. Then out_ready=1 -> outputs in order A,B,C,D at 1 per cycle, none lost, dec_count=4.
- HAS_M=0: mul (0x02208033) -> out_illegal=1, cls=0. With HAS_M=1 -> alu_op=0b10000, illegal=0.
- XLEN=64: lui 0x80000 (0x800000B7) -> imm=0xFFFFFFFF80000000. jal offset -2048 (0x801FF0EF) -> imm=0xFFFFFFFFFFFFF800.
- Flush with both entries full and in_valid=1 -> next cycle out_valid=0, in_ready=1, flushed entries never appear. Then rst mid-stream -> all outputs 0 and dec_count=0.
